// File: rtl/compositor_pkg.sv
// Shared types for the sprite compositor: sprite descriptor, FSM states and
// colour/address defaults.
package compositor_pkg;

  localparam int SPR_ADDR_W      = 20;
  localparam int COLOR_W_DEFAULT = 24;

  localparam logic [COLOR_W_DEFAULT-1:0] TRANSPARENT_DEFAULT = 24'h000000;

  // One sprite layer: enable, top-left corner, size and texel base address.
  typedef struct packed {
    logic                  en;
    logic [15:0]           x;
    logic [15:0]           y;
    logic [7:0]            w;
    logic [7:0]            h;
    logic [SPR_ADDR_W-1:0] base;
  } sprite_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EVAL
  } comp_state_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit test and texel address generation.
// The hit test runs on the live request coordinates so the hit vector can be
// captured on the accepting edge; the address uses the registered pixel
// coordinates that stay stable while the fetch loop runs.
module sprite_hit_unit
  import compositor_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W
) (
  input  sprite_desc_t      desc,
  input  logic [15:0]       req_x,
  input  logic [15:0]       req_y,
  input  logic [15:0]       cur_x,
  input  logic [15:0]       cur_y,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  // Right/bottom edges in 17 bits so a sprite near 16'hFFFF never wraps.
  logic [16:0] x_end;
  logic [16:0] y_end;
  logic [31:0] rel_x;
  logic [31:0] rel_y;
  logic [31:0] lin;

  assign x_end = {1'b0, desc.x} + {9'b0, desc.w};
  assign y_end = {1'b0, desc.y} + {9'b0, desc.h};

  assign hit = desc.en &&
               (req_x >= desc.x) && ({1'b0, req_x} < x_end) &&
               (req_y >= desc.y) && ({1'b0, req_y} < y_end);

  // Row-major texel offset inside the sprite, truncated to the RAM width.
  assign rel_x = 32'(cur_x) - 32'(desc.x);
  assign rel_y = 32'(cur_y) - 32'(desc.y);
  assign lin   = rel_y * 32'(desc.w) + rel_x;
  assign addr  = ADDR_W'(32'(desc.base) + lin);

endmodule

// File: rtl/sprite_compositor.sv
// Multi-layer sprite compositor for the VGA path.
// Walks the covering sprites in priority order (index 0 first), fetching one
// texel per ISSUE/EVAL pair, skipping transparent texels and falling back to
// the scrolling background, which is always treated as opaque.
// Optional feature: define SPRITE_COMPOSITOR_COLLIDE_EN to add the sticky
// per-sprite collide flags and the collide output port.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int                 NUM_SPRITES = 4,
  parameter int                 ADDR_W      = SPR_ADDR_W,
  parameter int                 COLOR_W     = COLOR_W_DEFAULT,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(TRANSPARENT_DEFAULT),
  parameter int                 BG_OFFSET   = 0,
  parameter int                 BG_W        = 640
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         pix_start,
  input  logic                         frame_start,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic [15:0]                  screen_offset,
  input  sprite_desc_t [NUM_SPRITES-1:0] spr,
  output logic [ADDR_W-1:0]            Addr,
  input  logic [COLOR_W-1:0]           Data_In,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         pix_valid,
  output logic                         busy
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  ,
  output logic [NUM_SPRITES-1:0]       collide
`endif
);

  localparam int          IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [31:0] BG_W_U   = 32'(BG_W);
  localparam logic [31:0] BG_OFF_U = 32'(BG_OFFSET);

  comp_state_t                         state;
  logic [15:0]                         req_x;
  logic [15:0]                         req_y;
  logic [15:0]                         act_x;
  logic [15:0]                         act_y;
  logic [NUM_SPRITES-1:0]              hit;
  logic [NUM_SPRITES-1:0]              pending;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0]  spr_addr;
  logic [ADDR_W-1:0]                   bg_addr;
  logic [IDX_W-1:0]                    cand_idx;
  logic                                cand_bg;
  logic [IDX_W-1:0]                    cur_idx;
  logic                                cur_bg;
  logic                                opaque;

  // Scrolled X wraps modulo 2^16; Y is the raw screen row.
  assign req_x = {6'b0, DrawX} + screen_offset;
  assign req_y = {6'b0, DrawY};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
      sprite_hit_unit #(
        .ADDR_W (ADDR_W)
      ) u_hit (
        .desc  (spr[gi]),
        .req_x (req_x),
        .req_y (req_y),
        .cur_x (act_x),
        .cur_y (act_y),
        .hit   (hit[gi]),
        .addr  (spr_addr[gi])
      );
    end
  endgenerate

  // Background texel: row-major with X wrapped to the background width.
  assign bg_addr = ADDR_W'(BG_OFF_U + 32'(act_y) * BG_W_U + 32'(act_x) % BG_W_U);

  // Lowest set pending bit is the highest-priority remaining sprite.
  always_comb begin
    cand_idx = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (pending[i]) cand_idx = IDX_W'(i);
    end
  end

  assign cand_bg = ~|pending;
  assign opaque  = cur_bg || (Data_In != TRANSPARENT);

  // Fetch loop: capture request, issue address, evaluate returned texel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Addr      <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      act_x     <= '0;
      act_y     <= '0;
      cur_idx   <= '0;
      cur_bg    <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pix_start) begin
            act_x   <= req_x;
            act_y   <= req_y;
            pending <= hit;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          Addr    <= cand_bg ? bg_addr : spr_addr[cand_idx];
          cur_idx <= cand_idx;
          cur_bg  <= cand_bg;
          state   <= EVAL;
        end
        EVAL: begin
          if (opaque) begin
            VGA_R     <= Data_In[COLOR_W-1  -: 8];
            VGA_G     <= Data_In[COLOR_W-9  -: 8];
            VGA_B     <= Data_In[COLOR_W-17 -: 8];
            pix_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            pending[cur_idx] <= 1'b0;
            state            <= ISSUE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  logic [NUM_SPRITES-1:0] others;

  // Sprites still pending besides the one supplying the pixel.
  assign others = pending & ~(NUM_SPRITES'(1) << cur_idx);

  // Sticky collision flags; a set in the same cycle as frame_start wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      collide <= '0;
    end else begin
      if (frame_start) collide <= '0;
      if (state == EVAL && !cur_bg && opaque && |others) collide[cur_idx] <= 1'b1;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: each accepted pixel pushes its
// expected colour and latency; the monitor pops and compares on pix_valid.
module tb_sprite_compositor;
  import compositor_pkg::*;

  localparam int NS = 4;

  logic                  Clk;
  logic                  Reset;
  logic                  pix_start;
  logic                  frame_start;
  logic [9:0]            DrawX;
  logic [9:0]            DrawY;
  logic [15:0]           screen_offset;
  sprite_desc_t [NS-1:0] spr;
  logic [19:0]           Addr;
  logic [23:0]           Data_In;
  logic [7:0]            VGA_R;
  logic [7:0]            VGA_G;
  logic [7:0]            VGA_B;
  logic                  pix_valid;
  logic                  busy;
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  logic [NS-1:0]         collide;
`endif

  logic [23:0] mem [0:(1<<20)-1];
  assign Data_In = mem[Addr];

  sprite_compositor #(
    .NUM_SPRITES (NS)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .pix_start     (pix_start),
    .frame_start   (frame_start),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .screen_offset (screen_offset),
    .spr           (spr),
    .Addr          (Addr),
    .Data_In       (Data_In),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B),
    .pix_valid     (pix_valid),
    .busy          (busy)
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    ,
    .collide       (collide)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  logic [23:0] q_rgb[$];
  int          q_lat[$];
  int          q_t[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge Clk) begin
    if (mon_on && pix_valid) begin
      if (q_rgb.size() == 0) begin
        chk("spurious_valid", pix_valid, 1'b0);
      end else begin
        logic [23:0] e_rgb;
        int e_lat;
        int t0;
        e_rgb = q_rgb.pop_front();
        e_lat = q_lat.pop_front();
        t0    = q_t.pop_front();
        chk("rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
        chk("latency", cyc - t0 - 1, e_lat);
      end
    end
  end

  function automatic logic [19:0] spr_addr(input int i, input logic [15:0] ax, input logic [15:0] ay);
    int unsigned row, col;
    row = int'(ay) - int'(spr[i].y);
    col = int'(ax) - int'(spr[i].x);
    return 20'(int'(spr[i].base) + row * int'(spr[i].w) + col);
  endfunction

  function automatic bit spr_hit(input int i, input logic [15:0] ax, input logic [15:0] ay);
    int xe, ye;
    xe = int'(spr[i].x) + int'(spr[i].w);
    ye = int'(spr[i].y) + int'(spr[i].h);
    return spr[i].en && int'(ax) >= int'(spr[i].x) && int'(ax) < xe &&
           int'(ay) >= int'(spr[i].y) && int'(ay) < ye;
  endfunction

  // Reference compositing: priority walk, transparent skip, opaque background.
  task automatic model(input logic [15:0] ax, input logic [15:0] ay,
                       output logic [23:0] rgb, output int lat, output logic [19:0] a0);
    int k;
    bit first;
    logic [19:0] a;
    k = 0;
    first = 1'b1;
    a0 = '0;
    for (int i = 0; i < NS; i++) begin
      if (spr_hit(i, ax, ay)) begin
        a = spr_addr(i, ax, ay);
        if (first) a0 = a;
        first = 1'b0;
        if (mem[a] != 24'h000000) begin
          rgb = mem[a];
          lat = 2 * (k + 1);
          return;
        end
        k++;
      end
    end
    a = 20'(int'(ay) * 640 + int'(ax) % 640);
    if (first) a0 = a;
    rgb = mem[a];
    lat = 2 * (k + 1);
  endtask

  task automatic set_spr(input int i, input bit en, input int x, input int y,
                         input int w, input int h, input int base);
    spr[i].en   = en;
    spr[i].x    = 16'(x);
    spr[i].y    = 16'(y);
    spr[i].w    = 8'(w);
    spr[i].h    = 8'(h);
    spr[i].base = 20'(base);
  endtask

  // One pixel request. fixed=1 uses the given expectations instead of the model.
  task automatic pix(input int dx, input int dy, input int off,
                     input bit fixed, input logic [23:0] f_rgb, input int f_lat,
                     input logic [19:0] f_addr, input bit poke, input bit fs);
    logic [23:0] rgb;
    int lat;
    logic [19:0] a0;
    int n;
    model(16'(dx) + 16'(off), 16'(dy), rgb, lat, a0);
    if (fixed) begin
      rgb = f_rgb;
      lat = f_lat;
      a0  = f_addr;
    end
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    screen_offset = 16'(off);
    pix_start = 1'b1;
    q_rgb.push_back(rgb);
    q_lat.push_back(lat);
    q_t.push_back(cyc);
    @(negedge Clk);
    pix_start = 1'b0;
    @(negedge Clk);
    chk("addr_first", Addr, a0);
    if (poke) begin
      DrawX = 10'd0;
      DrawY = 10'd0;
      pix_start = 1'b1;
    end
    frame_start = fs;
    n = 0;
    while (busy && n < 40) begin
      @(negedge Clk);
      pix_start = 1'b0;
      frame_start = 1'b0;
      n++;
    end
    pix_start = 1'b0;
    frame_start = 1'b0;
    chk("idle_after", busy, 1'b0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    pix_start = 1'b0;
    frame_start = 1'b0;
    DrawX = '0;
    DrawY = '0;
    screen_offset = '0;
    spr = '0;
    for (int i = 0; i < (1 << 20); i++)
      mem[i] = ($urandom_range(3) == 0) ? 24'h000000 : 24'($urandom);

    repeat (3) @(negedge Clk);
    chk("rst_addr", Addr, 20'h0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    chk("rst_collide", collide, 4'h0);
`endif
    Reset = 1'b0;
    mon_on = 1'b1;
    @(negedge Clk);

    // Background only.
    mem[50*640+100] = 24'h5C94FC;
    pix(100, 50, 0, 1'b1, 24'h5C94FC, 2, 20'(50*640+100), 1'b0, 1'b0);
    // Background texel equal to the key is still shown.
    mem[50*640+200] = 24'h000000;
    pix(200, 50, 0, 1'b1, 24'h000000, 2, 20'(50*640+200), 1'b0, 1'b0);

    // Single opaque sprite.
    set_spr(0, 1'b1, 96, 40, 16, 16, 'h100);
    mem['h1A4] = 24'hFF0000;
    pix(100, 50, 0, 1'b1, 24'hFF0000, 2, 20'h1A4, 1'b0, 1'b0);

    // Sprite0 transparent, sprite1 opaque.
    set_spr(1, 1'b1, 90, 45, 20, 20, 'h2000);
    mem['h1A4] = 24'h000000;
    mem['h206E] = 24'h00FF00;
    pix(100, 50, 0, 1'b1, 24'h00FF00, 4, 20'h1A4, 1'b0, 1'b0);
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    chk("collide_none", collide, 4'h0);
`endif

    // All four sprites transparent, background wins; extra pix_start mid-fetch ignored.
    set_spr(2, 1'b1, 100, 50, 4, 4, 'h3000);
    set_spr(3, 1'b1, 0, 0, 200, 100, 'h40000);
    mem['h206E] = 24'h000000;
    mem['h3000] = 24'h000000;
    mem['h42774] = 24'h000000;
    pix(100, 50, 0, 1'b1, 24'h5C94FC, 10, 20'h1A4, 1'b1, 1'b0);

`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    // Sprite0 opaque over pending sprite2 sets collide[0]; frame_start clears.
    set_spr(1, 1'b0, 0, 0, 0, 0, 0);
    set_spr(3, 1'b0, 0, 0, 0, 0, 0);
    mem['h1A4] = 24'hFF0000;
    pix(100, 50, 0, 1'b1, 24'hFF0000, 2, 20'h1A4, 1'b0, 1'b0);
    chk("collide_set", collide, 4'b0001);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("collide_clr", collide, 4'b0000);
    // frame_start in the same cycle as the set: the set wins.
    pix(100, 50, 0, 1'b1, 24'hFF0000, 2, 20'h1A4, 1'b0, 1'b1);
    chk("collide_win", collide, 4'b0001);
`endif

    // Reset while in EVAL aborts the fetch.
    set_spr(0, 1'b1, 96, 40, 16, 16, 'h100);
    mem['h1A4] = 24'hFF0000;
    DrawX = 10'd100;
    DrawY = 10'd50;
    screen_offset = 16'd0;
    pix_start = 1'b1;
    @(negedge Clk);
    pix_start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_addr", Addr, 20'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", pix_valid, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_novalid", pix_valid, 1'b0);
    pix(100, 50, 0, 1'b0, 24'h0, 0, 20'h0, 1'b0, 1'b0);

    // Scroll wrap of the background and 16-bit ActualX wrap.
    spr = '0;
    pix(630, 20, 20, 1'b0, 24'h0, 0, 20'h0, 1'b0, 1'b0);
    pix(32, 7, 'hFFF0, 1'b0, 24'h0, 0, 20'h0, 1'b0, 1'b0);

    // Sprite at the right edge of X space does not wrap to small X.
    set_spr(0, 1'b1, 'hFFF8, 0, 16, 100, 'h500);
    mem['h500 + 10*16 + 4] = 24'h123456;
    pix(12, 10, 'hFFF0, 1'b1, 24'h123456, 2, 20'('h500 + 10*16 + 4), 1'b0, 1'b0);
    pix(20, 10, 'hFFF0, 1'b1, mem[10*640+4], 2, 20'(10*640+4), 1'b0, 1'b0);

    // Random overlapping sprites against the model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NS; i++)
        set_spr(i, $urandom_range(3) != 0, $urandom_range(60), $urandom_range(60),
                $urandom_range(24, 1), $urandom_range(24, 1), $urandom_range((1 << 20) - 1));
      pix($urandom_range(70), $urandom_range(70), $urandom_range(15),
          1'b0, 24'h0, 0, 20'h0, 1'b0, 1'b0);
    end

    repeat (5) @(negedge Clk);
    chk("queue_empty", q_rgb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
